player_ctrl: RTL and testbench
==============================

# player_ctrl

Per-player motion and collision controller for the Tron light-cycle game. It sits directly upstream of `draw_object` in the 40 MHz pixel domain and consumes the synchronized 4-bit direction switches (`p1_info`) and the VGA vertical sync. It advances the cycle head one grid cell per game tick and checks each target cell against the trail BRAM, reading it over a 1-cycle-latency port. It issues trail writes and reports head position and crash status for rendering.

## Interface
- `GRID_COLS`, 100: grid width in cells (8×8-pixel cells on 800×600).
- `GRID_ROWS`, 75: grid height in cells.
- `TICK_FRAMES`, 4: frames per movement step (1..15).
- `START_COL`, 25 / `START_ROW`, 37: head position after reset and on start.
- `clock` input 1: 40 MHz pixel clock; the only clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `vs` input 1: VGA vertical sync, level, active high.
- `start` input 1: synchronized serve/start level; the block acts on its rising edge.
- `dir_in` input 4: one-hot request `{up, down, left, right}`, already synchronized.
- `trail_re` output 1: trail BRAM read enable.
- `trail_raddr` output 13: read address, `row*GRID_COLS+col`.
- `trail_rdata` input 1: occupied bit, valid 1 cycle after `trail_re`.
- `trail_we` output 1: trail write strobe; the write data is implicitly 1.
- `trail_waddr` output 13: write address.
- `clear_req` output 1: 1-cycle pulse telling the trail owner to clear the RAM.
- `head_col` output 7 / `head_row` output 7: current head cell.
- `heading` output 2: 0=up, 1=down, 2=left, 3=right.
- `running` output 1 / `crashed` output 1: game status.

## Operation
- States: IDLE, RUN, READ, CHECK, CRASH.
- Reset values:
  - state IDLE; head at (`START_COL`, `START_ROW`); heading right.
  - frame count 0; pending direction right.
  - all strobes 0; `running` = 0; `crashed` = 0.
- IDLE, on a `start` rising edge:
  - pulse `clear_req`;
  - reload the start position and heading right;
  - zero the frame count;
  - go to RUN.
- Direction latch, active in every state:
  - `dir_in` with exactly one bit set becomes the pending direction, unless it is the reverse of the current `heading`.
  - Zero bits set, multiple bits set, or a reversal: the latch holds its value.
  - `heading` takes the pending value only when a step commits.
- Frame pulse: a rising edge of `vs` (registered `vs` AND NOT previous).
- RUN:
  - Each frame pulse increments the frame count.
  - When the count equals `TICK_FRAMES-1`, the count wraps to 0 and a step starts.
- Step:
  - next cell = head + unit vector of the pending direction.
  - If next is off-grid (col 0 going left, col `GRID_COLS-1` going right, and likewise for rows): go straight to CRASH. No read is issued and there is no wrap-around.
  - Otherwise go to READ and drive `trail_re` with the next-cell address.
- CHECK samples `trail_rdata`:
  - 1: go to CRASH.
  - 0: commit the step. Pulse `trail_we` with the old head address; head ← next; heading ← pending; return to RUN.
- CRASH: `crashed` = 1, `running` = 0, and the head is frozen. A `start` rising edge behaves exactly as it does in IDLE.
- A `start` edge in RUN, READ or CHECK is ignored.
- Address arithmetic: `row*100` is computed as `(row<<6)+(row<<5)+(row<<2)`, 13 bits wide. The maximum address is 7499.
- `reset_n` asserted mid-step: everything returns to reset values immediately; any pending read is abandoned.

## Timing
- All outputs are registered.
- Frame pulse at edge T with the count at `TICK_FRAMES-1`:
  - T+1: `trail_re`=1 and `trail_raddr` valid (state READ), or CRASH if off-grid.
  - T+2: CHECK samples `trail_rdata`.
  - T+3: `trail_we` pulse plus the head/heading update, or `crashed`=1.
- `trail_re`, `trail_we` and `clear_req` are each high for exactly 1 cycle.
- `trail_we` and `trail_re` are never high in the same cycle.
- The 4-cycle step is far shorter than a frame, so a frame pulse never arrives during READ or CHECK. If one does, it is still counted.
- `clear_req` is asserted at the edge that enters RUN, and `running`=1 from that same edge.

## Structure
- Package `tron_pkg`:
  - `dir_t` enum (UP, DOWN, LEFT, RIGHT);
  - `pc_state_t` enum;
  - grid constants;
  - function `cell_addr(row, col)`.
- One sub-module, `edge_detect` (registered rising-edge pulse), instantiated for `vs` and for `start`.

## Test plan
- Reset, then `start` edge → `clear_req` 1 cycle; `running`=1; head (25,37); heading 3.
- `TICK_FRAMES`=4, `trail_rdata`=0, 8 `vs` pulses, no input:
  - exactly 2 `trail_we` pulses, at addresses 3725 and 3726;
  - final head (27,37).
- `dir_in`=4'b0010 (left) while heading right → ignored, head keeps moving right. Then 4'b1000 → after the next step the head is at row 36 and heading is 0. `dir_in`=4'b1100 → ignored.
- At head (99,10) heading right, next tick → no `trail_re`; `crashed`=1 at T+1; head stays (99,10).
- `trail_rdata`=1 at the CHECK cycle → `crashed`=1 at T+3, no `trail_we`. Then a `start` edge → `clear_req`, head (25,37), `running`=1.
- `reset_n` low at T+2 of a step → all outputs at reset values at once, no `trail_we` afterwards.

Source files
------------

// File: rtl/player_ctrl_pkg.sv
// Shared types and constants for the light-cycle player controller.
//   dir_t      : heading / direction encoding (0=up, 1=down, 2=left, 3=right)
//   pc_state_t : controller FSM states
//   cell_addr  : row-major trail RAM address for a 100-column grid
package tron_pkg;

    localparam int GRID_COLS_DEF   = 100;
    localparam int GRID_ROWS_DEF   = 75;
    localparam int TICK_FRAMES_DEF = 4;
    localparam int START_COL_DEF   = 25;
    localparam int START_ROW_DEF   = 37;

    localparam int COORD_W = 7;
    localparam int ADDR_W  = 13;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_READ  = 3'd2,
        S_CHECK = 3'd3,
        S_CRASH = 3'd4
    } pc_state_t;

    // row*100 + col without a multiplier: 100 = 64 + 32 + 4.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] row,
                                                    input logic [COORD_W-1:0] col);
        logic [ADDR_W-1:0] r;
        logic [ADDR_W-1:0] c;
        r = {{(ADDR_W-COORD_W){1'b0}}, row};
        c = {{(ADDR_W-COORD_W){1'b0}}, col};
        return (r << 6) + (r << 5) + (r << 2) + c;
    endfunction

    // The encoding pairs opposite directions as {0,1} and {2,3}, so two
    // directions are reverses exactly when they differ only in bit 0.
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a ^ b) == 2'b01;
    endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// Trail RAM port between the player controller (master) and the trail
// RAM owner (slave).
//   trail_re / trail_raddr : read request; trail_rdata valid the next cycle
//   trail_rdata            : occupied bit returned by the RAM
//   trail_we / trail_waddr : write strobe, data implicitly 1
//   clear_req              : request to clear the whole RAM
// All strobes are single-cycle pulses with no back-pressure: the RAM
// owner must accept every read, write and clear in the cycle it is
// presented, and it returns read data exactly one cycle after trail_re.
interface player_ctrl_if;
    import tron_pkg::*;

    logic              trail_re;
    logic [ADDR_W-1:0] trail_raddr;
    logic              trail_rdata;
    logic              trail_we;
    logic [ADDR_W-1:0] trail_waddr;
    logic              clear_req;

    modport master (
        output trail_re, trail_raddr, trail_we, trail_waddr, clear_req,
        input  trail_rdata
    );

    modport slave (
        input  trail_re, trail_raddr, trail_we, trail_waddr, clear_req,
        output trail_rdata
    );
endinterface

// File: rtl/player_ctrl_edge_detect.sv
// Registered rising-edge detector.
//   clock, reset_n : clock and asynchronous active-low reset
//   sig_in         : level input (already synchronous to clock)
//   pulse          : one-cycle pulse, high the cycle after sig_in rises
module edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic sig_in,
    output logic pulse
);
    logic sig_q, sig_d;
    logic prev_q, prev_d;

    always_comb begin
        sig_d  = sig_in;
        prev_d = sig_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sig_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = sig_q & ~prev_q;
endmodule

// File: rtl/player_ctrl.sv
// Per-player motion and collision controller for the light-cycle game.
// Advances the head one grid cell every TICK_FRAMES frames, checks the
// target cell against the trail RAM, marks the vacated cell and reports
// head position and game status.
//   clock, reset_n : pixel clock, asynchronous active-low reset
//   vs             : vertical sync level; its rising edge is a frame
//   start          : serve/start level; its rising edge starts a game
//   dir_in         : one-hot {up, down, left, right} request
//   trail          : trail RAM port (master side)
//   head_col/row   : current head cell
//   heading        : current heading (dir_t encoding)
//   running/crashed: game status
//   dbg_state      : controller FSM state
module player_ctrl
    import tron_pkg::*;
#(
    parameter int GRID_COLS   = GRID_COLS_DEF,
    parameter int GRID_ROWS   = GRID_ROWS_DEF,
    parameter int TICK_FRAMES = TICK_FRAMES_DEF,
    parameter int START_COL   = START_COL_DEF,
    parameter int START_ROW   = START_ROW_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               vs,
    input  logic               start,
    input  logic [3:0]         dir_in,
    player_ctrl_if.master      trail,
    output logic [COORD_W-1:0] head_col,
    output logic [COORD_W-1:0] head_row,
    output logic [1:0]         heading,
    output logic               running,
    output logic               crashed,
    output pc_state_t          dbg_state
);
    logic frame_pulse;
    logic start_pulse;

    edge_detect u_vs_edge (
        .clock  (clock),
        .reset_n(reset_n),
        .sig_in (vs),
        .pulse  (frame_pulse)
    );

    edge_detect u_start_edge (
        .clock  (clock),
        .reset_n(reset_n),
        .sig_in (start),
        .pulse  (start_pulse)
    );

    pc_state_t          state_q, state_d;
    logic [COORD_W-1:0] head_col_q, head_col_d, head_row_q, head_row_d;
    logic [COORD_W-1:0] next_col_q, next_col_d, next_row_q, next_row_d;
    dir_t               heading_q, heading_d, pend_q, pend_d, step_dir_q, step_dir_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               trail_re_q, trail_re_d, trail_we_q, trail_we_d;
    logic               clear_req_q, clear_req_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d, waddr_q, waddr_d;
    logic               running_q, running_d, crashed_q, crashed_d;

    // Decoded direction request.
    logic dir_valid;
    dir_t dir_req;

    always_comb begin
        dir_valid = 1'b1;
        dir_req   = RIGHT;
        case (dir_in)
            4'b1000: dir_req = UP;
            4'b0100: dir_req = DOWN;
            4'b0010: dir_req = LEFT;
            4'b0001: dir_req = RIGHT;
            default: dir_valid = 1'b0;
        endcase
    end

    // Candidate next cell from the pending direction, plus the edge test.
    logic [COORD_W-1:0] cand_col, cand_row;
    logic               off_grid;

    always_comb begin
        cand_col = head_col_q;
        cand_row = head_row_q;
        off_grid = 1'b0;
        case (pend_q)
            UP: begin
                off_grid = (head_row_q == '0);
                cand_row = head_row_q - 7'd1;
            end
            DOWN: begin
                off_grid = (head_row_q == 7'(GRID_ROWS - 1));
                cand_row = head_row_q + 7'd1;
            end
            LEFT: begin
                off_grid = (head_col_q == '0);
                cand_col = head_col_q - 7'd1;
            end
            default: begin
                off_grid = (head_col_q == 7'(GRID_COLS - 1));
                cand_col = head_col_q + 7'd1;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        head_col_d  = head_col_q;
        head_row_d  = head_row_q;
        next_col_d  = next_col_q;
        next_row_d  = next_row_q;
        heading_d   = heading_q;
        pend_d      = pend_q;
        step_dir_d  = step_dir_q;
        frame_cnt_d = frame_cnt_q;
        trail_re_d  = 1'b0;
        trail_we_d  = 1'b0;
        clear_req_d = 1'b0;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        running_d   = running_q;
        crashed_d   = crashed_q;

        if (dir_valid && !is_reverse(dir_req, heading_q)) begin
            pend_d = dir_req;
        end

        // Frames are counted in every active state, so a stray frame
        // during a step still advances the tick.
        if (frame_pulse && (state_q == S_RUN || state_q == S_READ || state_q == S_CHECK)) begin
            if (frame_cnt_q == 4'(TICK_FRAMES - 1)) begin
                frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + 4'd1;
            end
        end

        case (state_q)
            S_IDLE, S_CRASH: begin
                if (start_pulse) begin
                    clear_req_d = 1'b1;
                    head_col_d  = 7'(START_COL);
                    head_row_d  = 7'(START_ROW);
                    heading_d   = RIGHT;
                    // A new game must not inherit a pending turn that
                    // would be a reversal of the fresh heading.
                    pend_d      = RIGHT;
                    frame_cnt_d = '0;
                    running_d   = 1'b1;
                    crashed_d   = 1'b0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (frame_pulse && frame_cnt_q == 4'(TICK_FRAMES - 1)) begin
                    step_dir_d = pend_q;
                    if (off_grid) begin
                        running_d = 1'b0;
                        crashed_d = 1'b1;
                        state_d   = S_CRASH;
                    end else begin
                        next_col_d = cand_col;
                        next_row_d = cand_row;
                        trail_re_d = 1'b1;
                        raddr_d    = cell_addr(cand_row, cand_col);
                        state_d    = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (trail.trail_rdata) begin
                    running_d = 1'b0;
                    crashed_d = 1'b1;
                    state_d   = S_CRASH;
                end else begin
                    trail_we_d = 1'b1;
                    waddr_d    = cell_addr(head_row_q, head_col_q);
                    head_col_d = next_col_q;
                    head_row_d = next_row_q;
                    heading_d  = step_dir_q;
                    state_d    = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            head_col_q  <= 7'(START_COL);
            head_row_q  <= 7'(START_ROW);
            next_col_q  <= '0;
            next_row_q  <= '0;
            heading_q   <= RIGHT;
            pend_q      <= RIGHT;
            step_dir_q  <= RIGHT;
            frame_cnt_q <= '0;
            trail_re_q  <= 1'b0;
            trail_we_q  <= 1'b0;
            clear_req_q <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            running_q   <= 1'b0;
            crashed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_col_q  <= head_col_d;
            head_row_q  <= head_row_d;
            next_col_q  <= next_col_d;
            next_row_q  <= next_row_d;
            heading_q   <= heading_d;
            pend_q      <= pend_d;
            step_dir_q  <= step_dir_d;
            frame_cnt_q <= frame_cnt_d;
            trail_re_q  <= trail_re_d;
            trail_we_q  <= trail_we_d;
            clear_req_q <= clear_req_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            running_q   <= running_d;
            crashed_q   <= crashed_d;
        end
    end

    assign trail.trail_re    = trail_re_q;
    assign trail.trail_raddr = raddr_q;
    assign trail.trail_we    = trail_we_q;
    assign trail.trail_waddr = waddr_q;
    assign trail.clear_req   = clear_req_q;
    assign head_col          = head_col_q;
    assign head_row          = head_row_q;
    assign heading           = heading_q;
    assign running           = running_q;
    assign crashed           = crashed_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed game scenarios, a scoreboard of
// expected trail read/write addresses and a monitor that checks them.
module tb_player_ctrl;
  import tron_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       vs = 1'b0;
  logic       start = 1'b0;
  logic       occ = 1'b0;
  logic [3:0] dir_in = 4'b0000;
  logic [6:0] head_col, head_row;
  logic [1:0] heading;
  logic       running, crashed;
  pc_state_t  dbg_state;

  player_ctrl_if trail_bus();
  assign trail_bus.trail_rdata = occ;

  player_ctrl dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .vs       (vs),
    .start    (start),
    .dir_in   (dir_in),
    .trail    (trail_bus),
    .head_col (head_col),
    .head_row (head_row),
    .heading  (heading),
    .running  (running),
    .crashed  (crashed),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_we = 0;
  int n_clr = 0;
  logic [12:0] exp_re_q[$];
  logic [12:0] exp_we_q[$];
  int m_col, m_row, m_dir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a strobe.
  always @(negedge clock) begin
    if (reset_n) begin
      if (trail_bus.trail_re && trail_bus.trail_we) begin
        n_cmp++;
        n_bad++;
        $display("FAIL re_we_overlap: both strobes high at %0t", $time);
      end
      if (trail_bus.trail_re) begin
        if (exp_re_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_re: addr %0d, expected no read", trail_bus.trail_raddr);
        end else begin
          chk("raddr", 32'(trail_bus.trail_raddr), 32'(exp_re_q.pop_front()));
        end
      end
      if (trail_bus.trail_we) begin
        n_we++;
        if (exp_we_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_we: addr %0d, expected no write", trail_bus.trail_waddr);
        end else begin
          chk("waddr", 32'(trail_bus.trail_waddr), 32'(exp_we_q.pop_front()));
        end
      end
      if (trail_bus.clear_req) n_clr++;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered and left at a falling clock edge.
  task automatic frame();
    vs = 1'b1;
    repeat (2) @(negedge clock);
    vs = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  // Push the trail traffic expected for the coming step.
  task automatic step_model(input bit abandon);
    int nc, nr;
    nc = m_col;
    nr = m_row;
    case (m_dir)
      0: nr--;
      1: nr++;
      2: nc--;
      default: nc++;
    endcase
    if (nc < 0 || nc > 99 || nr < 0 || nr > 74) return;
    exp_re_q.push_back(13'(nr * 100 + nc));
    if (occ || abandon) return;
    exp_we_q.push_back(13'(m_row * 100 + m_col));
    m_col = nc;
    m_row = nr;
  endtask

  task automatic tick();
    repeat (3) frame();
    step_model(1'b0);
    frame();
  endtask

  task automatic do_start();
    start = 1'b1;
    repeat (2) @(negedge clock);
    chk("start_clear_req", 32'(trail_bus.clear_req), 1);
    chk("start_running", 32'(running), 1);
    chk("start_crashed", 32'(crashed), 0);
    chk("start_head_col", 32'(head_col), 25);
    chk("start_head_row", 32'(head_row), 37);
    chk("start_heading", 32'(heading), 3);
    @(negedge clock);
    chk("clear_req_one_cycle", 32'(trail_bus.clear_req), 0);
    start = 1'b0;
    @(negedge clock);
    m_col = 25;
    m_row = 37;
    m_dir = 3;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int we_before;
    m_col = 25;
    m_row = 37;
    m_dir = 3;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_running", 32'(running), 0);
    chk("rst_crashed", 32'(crashed), 0);
    chk("rst_head_col", 32'(head_col), 25);
    chk("rst_head_row", 32'(head_row), 37);
    chk("rst_heading", 32'(heading), 3);
    chk("rst_strobes", 32'({trail_bus.trail_re, trail_bus.trail_we, trail_bus.clear_req}), 0);

    do_start();
    chk("clear_count_1", 32'(n_clr), 1);

    // Two steps right from (25,37): writes 3725 then 3726.
    tick();
    chk("t1_head_col", 32'(head_col), 26);
    tick();
    chk("t2_head_col", 32'(head_col), 27);
    chk("t2_head_row", 32'(head_row), 37);
    chk("t2_we_count", 32'(n_we), 2);

    // Reversal ignored, valid turn up taken, multi-hot ignored.
    dir_in = 4'b0010;
    tick();
    chk("rev_head_col", 32'(head_col), 28);
    chk("rev_heading", 32'(heading), 3);
    dir_in = 4'b1000;
    m_dir = 0;
    tick();
    chk("up_head_row", 32'(head_row), 36);
    chk("up_head_col", 32'(head_col), 28);
    chk("up_heading", 32'(heading), 0);
    dir_in = 4'b1100;
    tick();
    chk("multi_head_row", 32'(head_row), 35);
    chk("multi_heading", 32'(heading), 0);
    dir_in = 4'b0000;

    // Drive to (99,10) heading right.
    while (m_row > 10) tick();
    dir_in = 4'b0001;
    m_dir = 3;
    while (m_col < 99) tick();
    dir_in = 4'b0000;
    chk("edge_head_col", 32'(head_col), 99);
    chk("edge_head_row", 32'(head_row), 10);
    chk("edge_heading", 32'(heading), 3);

    // Off-grid step: crash at T+1 without any read.
    repeat (3) frame();
    step_model(1'b0);
    vs = 1'b1;
    repeat (2) @(negedge clock);
    chk("offgrid_crashed_t1", 32'(crashed), 1);
    chk("offgrid_running_t1", 32'(running), 0);
    chk("offgrid_no_re", 32'(trail_bus.trail_re), 0);
    vs = 1'b0;
    repeat (4) @(negedge clock);
    chk("offgrid_state", 32'(dbg_state), 32'(S_CRASH));
    chk("offgrid_head_col", 32'(head_col), 99);
    chk("offgrid_head_row", 32'(head_row), 10);

    // Restart from CRASH, then collide with an occupied cell.
    do_start();
    chk("clear_count_2", 32'(n_clr), 2);
    occ = 1'b1;
    repeat (3) frame();
    step_model(1'b0);
    vs = 1'b1;
    repeat (2) @(negedge clock);
    vs = 1'b0;
    @(negedge clock);
    chk("occ_crashed_t2", 32'(crashed), 0);
    @(negedge clock);
    chk("occ_crashed_t3", 32'(crashed), 1);
    chk("occ_running_t3", 32'(running), 0);
    chk("occ_no_we", 32'(trail_bus.trail_we), 0);
    chk("occ_head_col", 32'(head_col), 25);
    repeat (2) @(negedge clock);
    occ = 1'b0;
    do_start();
    chk("clear_count_3", 32'(n_clr), 3);

    // Reset during the CHECK cycle of a step.
    repeat (3) frame();
    step_model(1'b1);
    we_before = n_we;
    vs = 1'b1;
    repeat (2) @(negedge clock);
    vs = 1'b0;
    @(negedge clock);
    chk("mid_state_check", 32'(dbg_state), 32'(S_CHECK));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("mid_rst_running", 32'(running), 0);
    chk("mid_rst_crashed", 32'(crashed), 0);
    chk("mid_rst_head_col", 32'(head_col), 25);
    chk("mid_rst_head_row", 32'(head_row), 37);
    chk("mid_rst_heading", 32'(heading), 3);
    chk("mid_rst_strobes", 32'({trail_bus.trail_re, trail_bus.trail_we, trail_bus.clear_req}), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("mid_rst_no_we", 32'(n_we), 32'(we_before));
    chk("mid_rst_idle", 32'(dbg_state), 32'(S_IDLE));

    chk("re_queue_empty", 32'(exp_re_q.size()), 0);
    chk("we_queue_empty", 32'(exp_we_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
